// File: rtl/master_arb_ctrl_pkg.sv
// Shared definitions for the master-side arbiter link controller: FSM states, frame and code
// constants.
package master_arb_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReqTx,
    StWaitGrant,
    StAckTx,
    StCom,
    StEndTx,
    StHoldTx,
    StWaitRegrant
  } mac_state_e;

  localparam logic [2:0] REQ_START  = 3'b111;
  localparam logic [2:0] ACK_FRAME  = 3'b101;
  localparam logic [3:0] END_FRAME  = 4'b0110;
  localparam logic [3:0] HOLD_FRAME = 4'b0100;

  localparam logic [1:0] CODE_GRANT   = 2'b11;
  localparam logic [1:0] CODE_PREEMPT = 2'b10;

endpackage

// File: rtl/master_arb_ctrl_if.sv
// Core/arbiter-facing signal bundle of one master link controller.
interface master_arb_ctrl_if #(
  parameter int unsigned S_ID_WIDTH = 2
) ();
  logic                  req;
  logic [S_ID_WIDTH-1:0] req_slave;
  logic                  end_com;
  logic                  hold_ack;
  logic                  arb_in;
  logic                  arb_out;
  logic                  busy;
  logic                  granted;
  logic                  preempt_pend;
  logic                  held;
  logic                  done;

  // Core and arbiter side.
  modport master (
    output req, req_slave, end_com, hold_ack, arb_in,
    input  arb_out, busy, granted, preempt_pend, held, done
  );

  // Controller side.
  modport slave (
    input  req, req_slave, end_com, hold_ack, arb_in,
    output arb_out, busy, granted, preempt_pend, held, done
  );
endinterface

// File: rtl/master_arb_ctrl_rx.sv
// Decoder for arbiter-to-master frames: start bit, 2-bit code, one-cycle result pulse.
module arb_frame_rx
  import master_arb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstN,
  input  logic arb_i,
  output logic grant_p_o,
  output logic preempt_p_o
);
  logic [1:0] cnt_q, cnt_d;
  logic       code_hi_q, code_hi_d;
  logic       grant_q, grant_d;
  logic       preempt_q, preempt_d;

  always_comb begin
    cnt_d     = cnt_q;
    code_hi_d = code_hi_q;
    grant_d   = 1'b0;
    preempt_d = 1'b0;
    unique case (cnt_q)
      2'd0: if (arb_i) cnt_d = 2'd1;
      2'd1: begin
        code_hi_d = arb_i;
        cnt_d     = 2'd2;
      end
      2'd2: begin
        cnt_d     = 2'd0;
        grant_d   = ({code_hi_q, arb_i} == CODE_GRANT);
        preempt_d = ({code_hi_q, arb_i} == CODE_PREEMPT);
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q     <= 2'd0;
      code_hi_q <= 1'b0;
      grant_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      code_hi_q <= code_hi_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant_p_o   = grant_q;
  assign preempt_p_o = preempt_q;
endmodule

// File: rtl/master_arb_ctrl.sv
// Per-master serial link controller: sends REQ/ACK/END/HOLD frames, reacts to GRANT/PREEMPT.
module master_arb_ctrl
  import master_arb_ctrl_pkg::*;
#(
  parameter int unsigned NO_SLAVES  = 3,
  parameter int unsigned S_ID_WIDTH = $clog2(NO_SLAVES + 1)
) (
  input logic              clk,
  input logic              rstN,
  master_arb_ctrl_if.slave bus
);
  localparam int unsigned FrameW = 3 + S_ID_WIDTH + 1;
  localparam int unsigned CntW   = $clog2(FrameW);
  typedef logic [CntW-1:0] cnt_t;

  mac_state_e            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [FrameW-1:0]     sh_q, sh_d;
  logic [S_ID_WIDTH-1:0] id_q, id_d;
  logic arb_out_q, arb_out_d, busy_q, busy_d, granted_q, granted_d;
  logic pend_q, pend_d, held_q, held_d, done_q, done_d;
  logic grant_p, preempt_p;

  arb_frame_rx u_rx (
    .clk        (clk),
    .rstN       (rstN),
    .arb_i      (bus.arb_in),
    .grant_p_o  (grant_p),
    .preempt_p_o(preempt_p)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sh_q      <= '0;
      id_q      <= '0;
      arb_out_q <= 1'b0;
      busy_q    <= 1'b0;
      granted_q <= 1'b0;
      pend_q    <= 1'b0;
      held_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      id_q      <= id_d;
      arb_out_q <= arb_out_d;
      busy_q    <= busy_d;
      granted_q <= granted_d;
      pend_q    <= pend_d;
      held_q    <= held_d;
      done_q    <= done_d;
    end
  end

  // Frames are loaded MSB-first into sh on entry to a TX state and shifted one bit per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    sh_d    = sh_q << 1;
    id_d    = id_q;
    unique case (state_q)
      StIdle: if (bus.req) begin
        state_d = StReqTx;
        id_d    = bus.req_slave;
        sh_d    = {REQ_START, bus.req_slave, 1'b0};
      end
      StReqTx: begin
        if (cnt_q == cnt_t'(FrameW - 1)) state_d = StWaitGrant;
        else cnt_d = cnt_q + 1'b1;
      end
      StWaitGrant, StWaitRegrant: if (grant_p) begin
        state_d = StAckTx;
        sh_d    = {ACK_FRAME, {(FrameW - 3){1'b0}}};
      end
      StAckTx: begin
        if (cnt_q == cnt_t'(2)) state_d = StCom;
        else cnt_d = cnt_q + 1'b1;
      end
      StCom: begin
        if (bus.end_com) begin
          state_d = StEndTx;
          sh_d    = {END_FRAME, {(FrameW - 4){1'b0}}};
        end else if (bus.hold_ack && pend_q) begin
          state_d = StHoldTx;
          sh_d    = {HOLD_FRAME, {(FrameW - 4){1'b0}}};
        end
      end
      StEndTx: begin
        if (cnt_q == cnt_t'(3)) state_d = StIdle;
        else cnt_d = cnt_q + 1'b1;
      end
      StHoldTx: begin
        if (cnt_q == cnt_t'(3)) state_d = StWaitRegrant;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (state_d)
      StReqTx, StAckTx, StEndTx, StHoldTx: arb_out_d = sh_d[FrameW-1];
      StCom:                               arb_out_d = 1'b1;
      default:                             arb_out_d = 1'b0;
    endcase
    busy_d    = (state_d != StIdle);
    granted_d = (state_d == StCom);
    held_d    = (state_d == StWaitRegrant);
    done_d    = (state_q == StEndTx) && (state_d == StIdle);
    pend_d    = pend_q;
    // Leaving COM through END drops any pending preempt; so does completing the HOLD frame.
    if ((state_q == StCom && state_d == StEndTx) ||
        (state_q == StHoldTx && state_d == StWaitRegrant)) begin
      pend_d = 1'b0;
    end else if (preempt_p && (state_q == StAckTx || state_q == StCom)) begin
      pend_d = 1'b1;
    end
  end

  assign bus.arb_out      = arb_out_q;
  assign bus.busy         = busy_q;
  assign bus.granted      = granted_q;
  assign bus.preempt_pend = pend_q;
  assign bus.held         = held_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_master_arb_ctrl.sv
// Bench for master_arb_ctrl: directed and randomized transactions against a frame-level model.
module tb_master_arb_ctrl;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = $clog2(NS + 1);

  typedef bit bitq_t[$];

  logic clk;
  logic rstN;
  int   n_checks = 0;
  int   n_fail   = 0;

  master_arb_ctrl_if #(.S_ID_WIDTH(SW)) bus_if ();

  master_arb_ctrl #(.NO_SLAVES(NS), .S_ID_WIDTH(SW)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected status tuple {busy, granted, preempt_pend, held, done}.
  task automatic chk_st(input string tag, input bit b, input bit g, input bit p, input bit h,
                        input bit d);
    chk({tag, "_status"},
        32'({bus_if.busy, bus_if.granted, bus_if.preempt_pend, bus_if.held, bus_if.done}),
        32'({b, g, p, h, d}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n bits of val, MSB first.
  function automatic bitq_t mk(input int n, input logic [31:0] val);
    bitq_t q;
    q = {};
    for (int i = n - 1; i >= 0; i--) q.push_back(val[i]);
    return q;
  endfunction

  function automatic bitq_t req_frame(input int id);
    return mk(SW + 4, 32'((7 << (SW + 1)) | (id << 1)));
  endfunction

  task automatic expect_frame(input string tag, input bitq_t bits);
    foreach (bits[i]) begin
      chk(tag, 32'(bus_if.arb_out), 32'(bits[i]));
      chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
      step();
    end
  endtask

  // Arbiter frame: start bit, 2-bit code, then idle until the decoded pulse is consumed.
  task automatic arb_send(input string tag, input logic [1:0] code, input bit line);
    logic [2:0] f;
    f = {1'b1, code};
    for (int i = 2; i >= 0; i--) begin
      bus_if.arb_in = f[i];
      chk(tag, 32'(bus_if.arb_out), 32'(line));
      step();
    end
    bus_if.arb_in = 1'b0;
    chk(tag, 32'(bus_if.arb_out), 32'(line));
    step();
  endtask

  // path: 0 plain end, 1 preempt/hold/regrant then end, 2 preempt then end_com+hold_ack.
  // Starts in an IDLE cycle, ends observing the done cycle.
  task automatic run_txn(input int id, input int path, input int dwell_wg, input int dwell_com,
                         input bit noise);
    bus_if.req       = 1'b1;
    bus_if.req_slave = SW'(id);
    step();
    bus_if.req = 1'b0;
    expect_frame("req", req_frame(id));
    chk_st("wait_grant", 1, 0, 0, 0, 0);
    if (noise) begin
      arb_send("rsvd_code", 2'b01, 1'b0);
      chk_st("rsvd_code", 1, 0, 0, 0, 0);
      arb_send("wg_preempt", 2'b10, 1'b0);
      chk_st("wg_preempt", 1, 0, 0, 0, 0);
    end
    repeat (dwell_wg) begin
      chk("wg_line", 32'(bus_if.arb_out), 32'd0);
      step();
    end
    arb_send("grant", 2'b11, 1'b0);
    expect_frame("ack", mk(3, 32'b101));
    repeat (dwell_com) begin
      chk("com_line", 32'(bus_if.arb_out), 32'd1);
      chk_st("com", 1, 1, 0, 0, 0);
      bus_if.req = 1'($urandom_range(0, 1));
      step();
    end
    bus_if.req = 1'b0;
    if (path != 0) begin
      arb_send("preempt", 2'b10, 1'b1);
      chk_st("pend", 1, 1, 1, 0, 0);
    end
    if (path == 1) begin
      bus_if.hold_ack = 1'b1;
      step();
      bus_if.hold_ack = 1'b0;
      expect_frame("hold", mk(4, 32'b0100));
      chk_st("held", 1, 0, 0, 1, 0);
      arb_send("regrant", 2'b11, 1'b0);
      expect_frame("reack", mk(3, 32'b101));
      chk("recom_line", 32'(bus_if.arb_out), 32'd1);
      chk_st("recom", 1, 1, 0, 0, 0);
    end
    bus_if.end_com  = 1'b1;
    bus_if.hold_ack = (path == 2);
    step();
    bus_if.end_com  = 1'b0;
    bus_if.hold_ack = 1'b0;
    chk_st("end_first", 1, 0, 0, 0, 0);
    expect_frame("end", mk(4, 32'b0110));
    chk("done_line", 32'(bus_if.arb_out), 32'd0);
    chk_st("done", 0, 0, 0, 0, 1);
  endtask

  initial begin
    rstN             = 1'b0;
    bus_if.req       = 1'b0;
    bus_if.req_slave = '0;
    bus_if.end_com   = 1'b0;
    bus_if.hold_ack  = 1'b0;
    bus_if.arb_in    = 1'b0;
    #3;
    chk("reset_line", 32'(bus_if.arb_out), 32'd0);
    chk_st("reset", 0, 0, 0, 0, 0);
    #9 rstN = 1'b1;
    step();
    chk_st("idle", 0, 0, 0, 0, 0);

    // Grant frame while idle is ignored.
    arb_send("idle_grant", 2'b11, 1'b0);
    chk_st("idle_grant", 0, 0, 0, 0, 0);
    step();
    chk("idle_line", 32'(bus_if.arb_out), 32'd0);

    // Directed: plain, preempt/resume, simultaneous, ignored codes in WAIT_GRANT.
    run_txn(1, 0, 0, 2, 1'b0);
    step();
    chk_st("post_plain", 0, 0, 0, 0, 0);
    run_txn(2, 1, 1, 1, 1'b0);
    step();
    run_txn(3, 2, 0, 3, 1'b1);

    // Randomized transactions, some back-to-back from the done cycle.
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        step();
        chk_st("gap_idle", 0, 0, 0, 0, 0);
        chk("gap_line", 32'(bus_if.arb_out), 32'd0);
      end
      run_txn(int'($urandom_range(0, NS)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)));
    end
    step();

    // Reset asserted during the second start bit of a REQ frame.
    bus_if.req       = 1'b1;
    bus_if.req_slave = SW'(2);
    step();
    bus_if.req = 1'b0;
    chk("mid_bit0", 32'(bus_if.arb_out), 32'd1);
    step();
    chk("mid_bit1", 32'(bus_if.arb_out), 32'd1);
    #1 rstN = 1'b0;
    #1;
    chk("async_rst_line", 32'(bus_if.arb_out), 32'd0);
    chk_st("async_rst", 0, 0, 0, 0, 0);
    #2 rstN = 1'b1;
    step();
    chk_st("post_rst", 0, 0, 0, 0, 0);
    bus_if.req       = 1'b1;
    bus_if.req_slave = SW'(3);
    step();
    bus_if.req = 1'b0;
    expect_frame("req_after_rst", req_frame(3));
    chk("wg_after_rst", 32'(bus_if.arb_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
